// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared constants and types for the two-requester APB command
// arbiter (apb_req_arbiter) and its round-robin picker (apb_rr_arb2).
`timescale 1ns/1ps
package apb_arb_pkg;

  // Default widths matching the APB master bridge user port
  localparam int unsigned APB_ARB_AW      = 32'd9;
  localparam int unsigned APB_ARB_DW      = 32'd8;
  localparam int unsigned APB_ARB_TIMEOUT = 32'd16;

  // Arbiter FSM encoding
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_ISSUE = 2'd1;
  localparam arb_state_t ST_WAIT  = 2'd2;
  localparam arb_state_t ST_DONE  = 2'd3;

  // Requester identifier: 0 = requester 0, 1 = requester 1
  typedef logic req_id_t;

  // Convert a one-hot two-way grant into the winning requester ID
  function automatic req_id_t grant_to_id(input logic [1:0] grant);
    return (grant == 2'b10) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// apb_rr_arb2: two-way round-robin picker. Produces a combinational one-hot
// grant from the valid vector and a registered priority pointer; the pointer
// moves to the non-granted requester whenever the advance strobe fires.
`timescale 1ns/1ps
module apb_rr_arb2 (
  input  logic       pclk,
  input  logic       presetn,
  input  logic [1:0] i_valid,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic       r_ptr;
  logic [1:0] w_grant;

  // A lone requester always wins; with both pending the pointer holder wins
  always_comb begin
    w_grant = 2'b00;
    case (i_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
      default: w_grant = 2'b00;
    endcase
  end

  assign o_grant = w_grant;

  // After each accepted grant, priority passes to the other requester
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_ptr <= 1'b0;
    end else if (i_advance && (w_grant != 2'b00)) begin
      r_ptr <= ~w_grant[1];
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares the APB master bridge command port between two
// requesters. One command in flight at a time: IDLE accepts, ISSUE pulses
// transfer, WAIT tracks psel&penable&pready, DONE returns a one-cycle done.
// Optional build macro APB_ARB_TIMEOUT_EN adds a WAIT timeout that ends the
// command with err=1 after TIMEOUT wait cycles.
`timescale 1ns/1ps
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned AW      = APB_ARB_AW,
  parameter int unsigned DW      = APB_ARB_DW,
  parameter int unsigned TIMEOUT = APB_ARB_TIMEOUT
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          req0_valid,
  input  logic          req0_rw,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          req0_done,
  output logic          req0_err,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  input  logic          req1_rw,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          req1_done,
  output logic          req1_err,
  output logic [DW-1:0] req1_rdata,
  output logic          transfer,
  output logic          read_write,
  output logic [AW-1:0] apb_write_paddr,
  output logic [DW-1:0] apb_write_data,
  output logic [AW-1:0] apb_read_paddr,
  input  logic [DW-1:0] apb_read_data_out,
  input  logic          psel,
  input  logic          penable,
  input  logic          pready
);

  arb_state_t    r_state;
  req_id_t       r_owner;
  logic          r_transfer;
  logic          r_read_write;
  logic [AW-1:0] r_write_paddr;
  logic [DW-1:0] r_write_data;
  logic [AW-1:0] r_read_paddr;
  logic          r_done0, r_done1, r_err0, r_err1;
  logic [DW-1:0] r_rdata0, r_rdata1;

  logic [1:0]    w_valid;
  logic [1:0]    w_grant;
  logic          w_idle;
  logic          w_accept;
  req_id_t       w_acc_id;
  logic          w_acc_rw;
  logic [AW-1:0] w_acc_addr;
  logic [DW-1:0] w_acc_wdata;
  logic          w_complete;
  logic          w_expire;
  logic          w_finish;
  logic          w_err;

  assign w_valid    = {req1_valid, req0_valid};
  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept   = w_idle & (w_grant != 2'b00);
  assign w_acc_id   = grant_to_id(w_grant);
  assign req0_ready = w_idle & w_grant[0];
  assign req1_ready = w_idle & w_grant[1];

  apb_rr_arb2 u_rr (
    .pclk      (pclk),
    .presetn   (presetn),
    .i_valid   (w_valid),
    .i_advance (w_accept),
    .o_grant   (w_grant)
  );

  // Route the granted requester's payload toward the bridge registers
  always_comb begin
    if (w_acc_id) begin
      w_acc_rw    = req1_rw;
      w_acc_addr  = req1_addr;
      w_acc_wdata = req1_wdata;
    end else begin
      w_acc_rw    = req0_rw;
      w_acc_addr  = req0_addr;
      w_acc_wdata = req0_wdata;
    end
  end

  assign w_complete = psel & penable & pready;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 32'd1);
  logic [CNT_W-1:0] r_tmo_cnt;

  // Count WAIT cycles; cleared while in ISSUE so every command starts at zero
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_tmo_cnt <= {CNT_W{1'b0}};
    end else if (r_state == ST_ISSUE) begin
      r_tmo_cnt <= {CNT_W{1'b0}};
    end else if (r_state == ST_WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Expiry on the TIMEOUT-th WAIT cycle
  assign w_expire = ((32'(r_tmo_cnt) + 32'd1) == TIMEOUT);
`else
  // No watchdog: WAIT only ends on a real APB completion. TIMEOUT stays a
  // parameter so both builds present the same module interface.
  assign w_expire = 1'b0 & (TIMEOUT == 32'd0);
`endif

  assign w_finish = (r_state == ST_WAIT) & (w_complete | w_expire);
  assign w_err    = w_expire & ~w_complete;   // completion beats expiry

  // Command FSM and bridge-facing registers; addresses/data hold through WAIT
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state       <= ST_IDLE;
      r_owner       <= 1'b0;
      r_transfer    <= 1'b0;
      r_read_write  <= 1'b0;
      r_write_paddr <= {AW{1'b0}};
      r_write_data  <= {DW{1'b0}};
      r_read_paddr  <= {AW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state      <= ST_ISSUE;
            r_owner      <= w_acc_id;
            r_transfer   <= 1'b1;
            r_read_write <= w_acc_rw;
            if (w_acc_rw) begin
              r_read_paddr  <= w_acc_addr;
            end else begin
              r_write_paddr <= w_acc_addr;
              r_write_data  <= w_acc_wdata;
            end
          end
        end
        ST_ISSUE: begin
          r_transfer <= 1'b0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_finish) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_transfer <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle done/err/rdata to the owner; read data captured on completion
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= {DW{1'b0}};
      r_rdata1 <= {DW{1'b0}};
    end else begin
      r_done0  <= w_finish & ~r_owner;
      r_done1  <= w_finish &  r_owner;
      r_err0   <= w_finish & ~r_owner & w_err;
      r_err1   <= w_finish &  r_owner & w_err;
      r_rdata0 <= (w_finish && !r_owner && r_read_write && !w_err) ? apb_read_data_out : {DW{1'b0}};
      r_rdata1 <= (w_finish &&  r_owner && r_read_write && !w_err) ? apb_read_data_out : {DW{1'b0}};
    end
  end

  assign transfer        = r_transfer;
  assign read_write      = r_read_write;
  assign apb_write_paddr = r_write_paddr;
  assign apb_write_data  = r_write_data;
  assign apb_read_paddr  = r_read_paddr;
  assign req0_done       = r_done0;
  assign req1_done       = r_done1;
  assign req0_err        = r_err0;
  assign req1_err        = r_err1;
  assign req0_rdata      = r_rdata0;
  assign req1_rdata      = r_rdata1;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed bench for apb_req_arbiter with a small APB
// bridge/slave stand-in (setup -> access, programmable wait states or a
// held-low pready). Build with APB_ARB_TIMEOUT_EN to exercise the timeout.
`timescale 1ns/1ps
module tb_apb_req_arbiter;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       req0_valid = 1'b0, req0_rw = 1'b0;
  logic [8:0] req0_addr = 9'h000;
  logic [7:0] req0_wdata = 8'h00;
  logic       req1_valid = 1'b0, req1_rw = 1'b0;
  logic [8:0] req1_addr = 9'h000;
  logic [7:0] req1_wdata = 8'h00;
  logic       req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
  logic [7:0] req0_rdata, req1_rdata;
  logic       transfer, read_write;
  logic [8:0] apb_write_paddr, apb_read_paddr;
  logic [7:0] apb_write_data;
  logic [7:0] rd_bus = 8'h00;
  logic       psel, penable, pready;

  int errors = 0;
  int checks = 0;

  // Bridge stand-in
  logic [1:0] bst;
  int         wcnt;
  int         waits_cfg = 0;
  logic       hold_low = 1'b0;
  int         d0_cnt = 0, d1_cnt = 0;

  always #5 pclk = ~pclk;

  apb_req_arbiter #(.AW(9), .DW(8), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_done(req0_done), .req0_err(req0_err), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_done(req1_done), .req1_err(req1_err), .req1_rdata(req1_rdata),
    .transfer(transfer), .read_write(read_write),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr), .apb_read_data_out(rd_bus),
    .psel(psel), .penable(penable), .pready(pready)
  );

  // Bridge phases: 0 idle, 1 setup, 2 access
  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      bst  <= 2'd0;
      wcnt <= 0;
    end else begin
      case (bst)
        2'd0: if (transfer) bst <= 2'd1;
        2'd1: begin bst <= 2'd2; wcnt <= 0; end
        2'd2: if (pready) bst <= 2'd0; else wcnt <= wcnt + 1;
        default: bst <= 2'd0;
      endcase
    end
  end

  assign psel    = (bst != 2'd0);
  assign penable = (bst == 2'd2);
  assign pready  = (bst == 2'd2) && !hold_low && (wcnt >= waits_cfg);

  // Count done pulses per requester
  always @(posedge pclk) begin
    if (req0_done) d0_cnt <= d0_cnt + 1;
    if (req1_done) d1_cnt <= d1_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int id);
    return (id == 0) ? req0_done : req1_done;
  endfunction

  // Issue one command from requester id and follow it to its done pulse
  task automatic run_cmd(input string tag, input int id, input logic rw, input logic [8:0] addr,
                         input logic [7:0] wd, input int waits, input logic [7:0] rd);
    int   n;
    logic got;
    logic st_bad;
    @(negedge pclk);
    waits_cfg = waits;
    rd_bus    = rd;
    if (id == 0) begin
      req0_rw = rw; req0_addr = addr; req0_wdata = wd; req0_valid = 1'b1;
    end else begin
      req1_rw = rw; req1_addr = addr; req1_wdata = wd; req1_valid = 1'b1;
    end
    #1;
    check({tag, "_ready"}, 32'((id == 0) ? req0_ready : req1_ready), 32'd1);
    @(posedge pclk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge pclk);
    check({tag, "_transfer"}, 32'(transfer), 32'd1);
    check({tag, "_rw"}, 32'(read_write), 32'(rw));
    check({tag, "_addr"}, 32'(rw ? apb_read_paddr : apb_write_paddr), 32'(addr));
    if (!rw) check({tag, "_wdata"}, 32'(apb_write_data), 32'(wd));
    n = 0; got = 1'b0; st_bad = 1'b0;
    while (!got && n < 40) begin
      @(negedge pclk);
      n++;
      if (done_of(id)) got = 1'b1;
      else if (transfer !== 1'b0 || read_write !== rw ||
               (rw ? apb_read_paddr : apb_write_paddr) !== addr) st_bad = 1'b1;
    end
    check({tag, "_latency"}, 32'(n), 32'(3 + waits));
    check({tag, "_stable"}, 32'(st_bad), 32'd0);
    check({tag, "_err"}, 32'((id == 0) ? req0_err : req1_err), 32'd0);
    check({tag, "_rdata"}, 32'((id == 0) ? req0_rdata : req1_rdata), 32'(rw ? rd : 8'h00));
    @(negedge pclk);
    check({tag, "_pulse"}, 32'(done_of(id)), 32'd0);
  endtask

  initial begin
    int   bad;
    int   n;
    logic got;
    logic found;
    int   winner;
    int   n0, n1, d0_base, d1_base;

    // Reset values
    @(negedge pclk);
    check("rst_bridge", 32'({transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr}), 32'd0);
    check("rst_resp", 32'({req0_done, req1_done, req0_err, req1_err, req0_rdata, req1_rdata}), 32'd0);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(negedge pclk);
    presetn = 1'b1;

    // Reset while a read from req0 is stuck in WAIT
    @(negedge pclk);
    hold_low = 1'b1;
    req0_rw = 1'b1; req0_addr = 9'h105; req0_valid = 1'b1;
    @(posedge pclk);
    #1 req0_valid = 1'b0;
    @(negedge pclk);
    check("midrst_paddr", 32'(apb_read_paddr), 32'h105);
    repeat (3) @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    check("midrst_bridge", 32'({transfer, read_write, apb_write_paddr, apb_write_data, apb_read_paddr}), 32'd0);
    check("midrst_resp", 32'({req0_done, req1_done, req0_err, req1_err, req0_rdata, req1_rdata}), 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    hold_low = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge pclk);
      if (req0_done !== 1'b0 || req1_done !== 1'b0) bad++;
    end
    check("midrst_nodone", 32'(bad), 32'd0);
    @(negedge pclk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("midrst_grant", 32'({req1_ready, req0_ready}), 32'h1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge pclk);
    check("dropped_valid", 32'(transfer), 32'd0);

    // req0 write, zero-wait slave
    run_cmd("wr0", 0, 1'b0, 9'h012, 8'hA5, 0, 8'h77);
    // req1 read, two wait states
    run_cmd("rd1", 1, 1'b1, 9'h1F0, 8'h00, 2, 8'h3C);

    // Both requesters pending continuously: grants must alternate 0,1,0,1...
    d0_base = d0_cnt; d1_base = d1_cnt;
    n0 = 0; n1 = 0;
    waits_cfg = 0;
    @(negedge pclk);
    req0_rw = 1'b0; req0_addr = 9'h020; req0_wdata = 8'h11; req0_valid = 1'b1;
    req1_rw = 1'b0; req1_addr = 9'h021; req1_wdata = 8'h22; req1_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      found = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
        if (c != 0 || k != 0) @(negedge pclk);
        #1;
        if (req0_ready || req1_ready) found = 1'b1;
      end
      check("rr_found", 32'(found), 32'd1);
      if (found) begin
        check("rr_onehot", 32'(req0_ready & req1_ready), 32'd0);
        winner = req1_ready ? 1 : 0;
        check("rr_order", 32'(winner), 32'(k % 2));
        @(posedge pclk);
        #1;
        if (winner == 0) begin
          n0++;
          if (n0 == 4) req0_valid = 1'b0;
        end else begin
          n1++;
          if (n1 == 4) req1_valid = 1'b0;
        end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) @(negedge pclk);
    check("rr_done0", 32'(d0_cnt - d0_base), 32'd4);
    check("rr_done1", 32'(d1_cnt - d1_base), 32'd4);

`ifdef APB_ARB_TIMEOUT_EN
    // pready held low: watchdog ends the read with err after 16 WAIT cycles
    @(negedge pclk);
    hold_low = 1'b1; rd_bus = 8'hEE;
    req0_rw = 1'b1; req0_addr = 9'h0AA; req0_valid = 1'b1;
    @(posedge pclk);
    #1 req0_valid = 1'b0;
    @(negedge pclk);
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge pclk);
      n++;
      if (req0_done) got = 1'b1;
    end
    check("tmo_latency", 32'(n), 32'd17);
    check("tmo_err", 32'(req0_err), 32'd1);
    check("tmo_rdata", 32'(req0_rdata), 32'd0);
    hold_low = 1'b0;
    repeat (3) @(negedge pclk);
    run_cmd("post_tmo", 1, 1'b1, 9'h033, 8'h00, 1, 8'h5A);
`else
    // pready held low for 100 cycles: no done, no new transfer, then complete
    @(negedge pclk);
    hold_low = 1'b1;
    req0_rw = 1'b0; req0_addr = 9'h0AA; req0_wdata = 8'h55; req0_valid = 1'b1;
    @(posedge pclk);
    #1 req0_valid = 1'b0;
    @(negedge pclk);
    check("stall_transfer", 32'(transfer), 32'd1);
    bad = 0;
    repeat (100) begin
      @(negedge pclk);
      if (transfer !== 1'b0 || req0_done !== 1'b0 || req1_done !== 1'b0) bad++;
    end
    check("stall_quiet", 32'(bad), 32'd0);
    hold_low = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge pclk);
      n++;
      if (req0_done) got = 1'b1;
    end
    check("stall_latency", 32'(n), 32'd1);
    check("stall_err", 32'(req0_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
